// File: rtl/lsu_pkg.sv
// Shared types for the multi-cycle load/store unit: FSM states, funct3 op codes,
// exception codes and the access-size helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_D  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;
    localparam logic [2:0] OP_WU = 3'b110;

    typedef enum logic [1:0] {
        EXC_NONE   = 2'b00,
        EXC_LD_MIS = 2'b01,
        EXC_ST_MIS = 2'b10,
        EXC_BUS    = 2'b11
    } lsu_exc_t;

    // log2 of the access size in bytes; expects an already-normalised op
    function automatic logic [1:0] size_of(input logic [2:0] op);
        case (op)
            OP_B, OP_BU: size_of = 2'd0;
            OP_H, OP_HU: size_of = 2'd1;
            OP_D:        size_of = 2'd3;
            default:     size_of = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data/strobe placement into the bus lane and
// load data extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int  DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int LANE_W = $clog2(STRB_W)
) (
    input  logic [LANE_W-1:0] st_lane_i,
    input  logic [1:0]        st_size_i,
    input  logic [DATA_W-1:0] st_wdata_i,
    output logic [DATA_W-1:0] st_wdata_o,
    output logic [STRB_W-1:0] st_strb_o,
    input  logic [LANE_W-1:0] ld_lane_i,
    input  logic [2:0]        ld_op_i,
    input  logic [DATA_W-1:0] ld_rdata_i,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [STRB_W-1:0] strb_base;
    logic [DATA_W-1:0] byte_mask;
    logic [DATA_W-1:0] ld_sh;

    always_comb begin
        strb_base = '0;
        byte_mask = '0;
        for (int i = 0; i < STRB_W; i++) begin
            strb_base[i]       = (i < (1 << st_size_i));
            byte_mask[i*8 +: 8] = {8{strb_base[i]}};
        end
        st_strb_o  = strb_base << st_lane_i;
        // bytes beyond the access size are cleared so only strobed lanes carry data
        st_wdata_o = (st_wdata_i & byte_mask) << {st_lane_i, 3'b000};
    end

    always_comb begin
        ld_sh = ld_rdata_i >> {ld_lane_i, 3'b000};
        case (ld_op_i)
            OP_B:    ld_data_o = DATA_W'($signed(ld_sh[7:0]));
            OP_H:    ld_data_o = DATA_W'($signed(ld_sh[15:0]));
            OP_BU:   ld_data_o = DATA_W'(ld_sh[7:0]);
            OP_HU:   ld_data_o = DATA_W'(ld_sh[15:0]);
            OP_WU:   ld_data_o = DATA_W'(ld_sh[31:0]);
            OP_D:    ld_data_o = ld_sh;
            default: ld_data_o = DATA_W'($signed(ld_sh[31:0]));
        endcase
    end

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle LSU: one instruction in flight, one memory transaction per access,
// result (or exception) held for the WBU until accepted.
module lsu_mc
    import lsu_pkg::*;
#(
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 32,
    parameter int  PASS_W = 39,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            exu_valid,
    input  logic [ADDR_W+5+DATA_W+PASS_W-1:0] exu_data,
    output logic                            lsu_ready,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic [ADDR_W-1:0]               mem_req_addr,
    output logic                            mem_req_wen,
    output logic [DATA_W-1:0]               mem_req_wdata,
    output logic [STRB_W-1:0]               mem_req_wstrb,
    output logic [1:0]                      mem_req_size,
    input  logic                            mem_rsp_valid,
    input  logic [DATA_W-1:0]               mem_rsp_rdata,
    input  logic                            mem_rsp_err,
    output logic                            lsu_valid,
    output logic [DATA_W+PASS_W-1:0]        lsu_data,
    output logic [1:0]                      lsu_exc,
    input  logic                            wbu_ready
);

    localparam int LANE_W = $clog2(STRB_W);
    localparam bit WIDE   = (DATA_W == 64);

    logic [ADDR_W-1:0] in_addr;
    logic              in_ren, in_wen;
    logic [2:0]        in_op;
    logic [DATA_W-1:0] in_wdata;
    logic [PASS_W-1:0] in_pass;

    assign {in_addr, in_ren, in_wen, in_op, in_wdata, in_pass} = exu_data;

    logic [2:0] op_n;
    logic [1:0] size_n;
    logic [2:0] amask;
    logic       mis_n;

    // Stores only look at op[1:0]; any op without a defined meaning at this width becomes W.
    always_comb begin
        op_n = in_wen ? {1'b0, in_op[1:0]} : in_op;
        if (op_n == 3'b111 || (!WIDE && (op_n == OP_D || op_n == OP_WU)))
            op_n = OP_W;
        size_n = size_of(op_n);
        amask  = 3'((4'd1 << size_n) - 4'd1);
        mis_n  = |(in_addr[2:0] & amask);
    end

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [1:0]        size_q, size_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [DATA_W-1:0] res_q, res_d;
    lsu_exc_t          exc_q, exc_d;

    logic [DATA_W-1:0] st_wdata;
    logic [STRB_W-1:0] st_strb;
    logic [DATA_W-1:0] ld_data;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .st_lane_i  (in_addr[LANE_W-1:0]),
        .st_size_i  (size_n),
        .st_wdata_i (in_wdata),
        .st_wdata_o (st_wdata),
        .st_strb_o  (st_strb),
        .ld_lane_i  (addr_q[LANE_W-1:0]),
        .ld_op_i    (op_q),
        .ld_rdata_i (mem_rsp_rdata),
        .ld_data_o  (ld_data)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        size_d        = size_q;
        op_d          = op_q;
        wdata_d       = wdata_q;
        strb_d        = strb_q;
        pass_d        = pass_q;
        res_d         = res_q;
        exc_d         = exc_q;
        lsu_ready     = 1'b0;
        mem_req_valid = 1'b0;
        lsu_valid     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                lsu_ready = 1'b1;
                if (exu_valid) begin
                    addr_d  = in_addr;
                    wen_d   = in_wen;
                    size_d  = size_n;
                    op_d    = op_n;
                    pass_d  = in_pass;
                    res_d   = '0;
                    wdata_d = in_wen ? st_wdata : '0;
                    strb_d  = in_wen ? st_strb : '0;
                    exc_d   = EXC_NONE;
                    if (!(in_ren || in_wen)) begin
                        state_d = ST_OUT;
                    end else if (mis_n) begin
                        exc_d   = in_wen ? EXC_ST_MIS : EXC_LD_MIS;
                        state_d = ST_OUT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // store acknowledgements come through here too; their data is discarded
                if (mem_rsp_valid) begin
                    state_d = ST_OUT;
                    if (mem_rsp_err) begin
                        exc_d = EXC_BUS;
                        res_d = '0;
                    end else begin
                        res_d = wen_q ? '0 : ld_data;
                    end
                end
            end
            ST_OUT: begin
                lsu_valid = 1'b1;
                if (wbu_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            size_q  <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            pass_q  <= '0;
            res_q   <= '0;
            exc_q   <= EXC_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            pass_q  <= pass_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = strb_q;
    assign mem_req_size  = size_q;
    assign lsu_data      = {res_q, pass_q};
    assign lsu_exc       = exc_q;

endmodule

// File: tb/tb_lsu_mc.sv
// Bench for lsu_mc: directed vector table, randomized transactions against a
// byte-arithmetic reference model, and hand-written stall/reset sequences.
module tb_lsu_mc;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PW = 39;

    logic              clk = 1'b0;
    logic              rst;
    logic              exu_valid;
    logic [AW+5+DW+PW-1:0] exu_data;
    logic              lsu_ready;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_req_wen;
    logic [DW-1:0]     mem_req_wdata;
    logic [DW/8-1:0]   mem_req_wstrb;
    logic [1:0]        mem_req_size;
    logic              mem_rsp_valid;
    logic [DW-1:0]     mem_rsp_rdata;
    logic              mem_rsp_err;
    logic              lsu_valid;
    logic [DW+PW-1:0]  lsu_data;
    logic [1:0]        lsu_exc;
    logic              wbu_ready;

    lsu_mc #(.ADDR_W(AW), .DATA_W(DW), .PASS_W(PW)) dut (
        .clk(clk), .rst(rst), .exu_valid(exu_valid), .exu_data(exu_data),
        .lsu_ready(lsu_ready), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata),
        .mem_req_wstrb(mem_req_wstrb), .mem_req_size(mem_req_size),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .lsu_valid(lsu_valid), .lsu_data(lsu_data), .lsu_exc(lsu_exc), .wbu_ready(wbu_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        ren, wen;
        bit [2:0]  op;
        bit [31:0] addr, wdata, rdata;
        bit        err;
        bit [38:0] pass;
        int        rd, rs, ws;   // response delay, request stall, WBU stall (cycles)
        bit        stray;        // inject ignorable responses in REQ/OUT
    } stim_t;

    typedef struct {
        bit        mem;
        bit [31:0] res;
        bit [1:0]  exc;
        bit [31:0] wdata;
        bit [3:0]  strb;
        bit [1:0]  size;
        int        lat;
    } exp_t;

    typedef struct {
        int          lat, nhs, nreq;
        bit          unst, rdy_bad, out_unst, after_ok, idle_rdy;
        logic [31:0] addr, wdata, res;
        logic [3:0]  strb;
        logic [1:0]  size, exc;
        logic        wen;
        logic [38:0] pass;
    } obs_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: access size in bytes, lane = addr mod 4, plain shifts/masks and
    // two's-complement subtraction for sign extension.
    function automatic exp_t model(input stim_t s);
        exp_t            e;
        int              nb, lane;
        bit              sgn;
        longint unsigned mask, v;
        e = '{default: 0};
        sgn = 1'b1;
        if (s.wen) nb = (s.op[1:0] == 2'd3) ? 4 : (1 << s.op[1:0]);
        else begin
            case (s.op)
                3'd0: nb = 1;
                3'd1: nb = 2;
                3'd4: begin nb = 1; sgn = 1'b0; end
                3'd5: begin nb = 2; sgn = 1'b0; end
                default: nb = 4;
            endcase
        end
        lane = int'(s.addr[1:0]);
        e.lat = 1;
        if (!(s.ren || s.wen)) return e;
        if (lane % nb != 0) begin
            e.exc = s.wen ? 2'd2 : 2'd1;
            return e;
        end
        e.mem  = 1'b1;
        e.size = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
        e.lat  = 3 + s.rs + s.rd;
        mask   = (64'd1 << (8 * nb)) - 64'd1;
        if (s.wen) begin
            e.strb  = 4'(((1 << nb) - 1) << lane);
            e.wdata = 32'((64'(s.wdata) & mask) << (8 * lane));
        end
        if (s.err) e.exc = 2'd3;
        else if (!s.wen) begin
            v = (64'(s.rdata) >> (8 * lane)) & mask;
            if (sgn && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
            e.res = 32'(v);
        end
        return e;
    endfunction

    // Plays EXU, memory and WBU for one instruction; called at a negedge.
    task automatic run_txn(input stim_t s, output obs_t o);
        bit               hs, sent;
        int               st, k;
        logic [DW+PW-1:0] od;
        logic [1:0]       oe;
        o = '{default: 0};
        hs = 0; sent = 0; st = 0; k = 0;
        o.idle_rdy = lsu_ready;
        exu_valid = 1'b1;
        exu_data  = {s.addr, s.ren, s.wen, s.op, s.wdata, s.pass};
        @(negedge clk);
        exu_valid = 1'b0;
        exu_data  = '0;
        for (int c = 0; c < 200; c++) begin
            mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_err = 0; mem_rsp_rdata = '0;
            if (lsu_valid) begin o.lat = c + 1; break; end
            if (lsu_ready) o.rdy_bad = 1;
            if (mem_req_valid) begin
                if (o.nreq == 0) begin
                    o.addr = mem_req_addr; o.wen = mem_req_wen; o.wdata = mem_req_wdata;
                    o.strb = mem_req_wstrb; o.size = mem_req_size;
                end else if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb, mem_req_size}
                             !== {o.addr, o.wen, o.wdata, o.strb, o.size}) o.unst = 1;
                o.nreq++;
                if (st >= s.rs) begin
                    mem_req_ready = 1; o.nhs++; hs = 1;
                end else if (s.stray) begin
                    mem_rsp_valid = 1; mem_rsp_err = 1; mem_rsp_rdata = $urandom;
                end
                st++;
            end else if (hs && !sent) begin
                k++;
                if (k > s.rd) begin
                    mem_rsp_valid = 1; mem_rsp_rdata = s.rdata; mem_rsp_err = s.err; sent = 1;
                end
            end
            @(negedge clk);
        end
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_err = 0;
        if (o.lat != 0) begin
            od = lsu_data; oe = lsu_exc;
            o.res = od[DW+PW-1:PW]; o.pass = od[PW-1:0]; o.exc = oe;
            for (int c = 0; c < s.ws; c++) begin
                if (s.stray) begin mem_rsp_valid = 1; mem_rsp_err = 1; mem_rsp_rdata = $urandom; end
                @(negedge clk);
                mem_rsp_valid = 0; mem_rsp_err = 0;
                if (!lsu_valid || lsu_data !== od || lsu_exc !== oe || lsu_ready) o.out_unst = 1;
            end
            wbu_ready = 1'b1;
            @(negedge clk);
            wbu_ready = 1'b0;
            o.after_ok = !lsu_valid && lsu_ready;
        end
    endtask

    task automatic verify(input string tag, input stim_t s, input exp_t e, input obs_t o);
        chk({tag, " latency"}, 64'(o.lat), 64'(e.lat));
        chk({tag, " result"}, 64'(o.res), 64'(e.res));
        chk({tag, " exc"}, 64'(o.exc), 64'(e.exc));
        chk({tag, " pass"}, 64'(o.pass), 64'(s.pass));
        chk({tag, " handshakes"}, 64'(o.nhs), e.mem ? 64'd1 : 64'd0);
        chk({tag, " ready_at_accept"}, 64'(o.idle_rdy), 64'd1);
        chk({tag, " ready_while_busy"}, 64'(o.rdy_bad), 64'd0);
        chk({tag, " out_stable"}, 64'(o.out_unst), 64'd0);
        chk({tag, " back_to_idle"}, 64'(o.after_ok), 64'd1);
        if (e.mem) begin
            chk({tag, " req_addr"}, 64'(o.addr), 64'(s.addr));
            chk({tag, " req_wen"}, 64'(o.wen), 64'(s.wen));
            chk({tag, " req_wdata"}, 64'(o.wdata), 64'(e.wdata));
            chk({tag, " req_wstrb"}, 64'(o.strb), 64'(e.strb));
            chk({tag, " req_size"}, 64'(o.size), 64'(e.size));
            chk({tag, " req_cycles"}, 64'(o.nreq), 64'(s.rs + 1));
            chk({tag, " req_stable"}, 64'(o.unst), 64'd0);
        end
    endtask

    task automatic add_vec(input bit ren, wen, input bit [2:0] op, input bit [31:0] addr, wdata, rdata,
                           input bit err, input int rd, rs, ws, input bit em, input bit [31:0] eres,
                           input bit [1:0] eexc, input bit [31:0] ewd, input bit [3:0] estrb,
                           input bit [1:0] esize, input int elat);
        vec_t v;
        v.s = '{ren: ren, wen: wen, op: op, addr: addr, wdata: wdata, rdata: rdata, err: err,
                pass: 39'(vq.size() * 1234567 + 7), rd: rd, rs: rs, ws: ws, stray: (rs > 0)};
        v.e = '{mem: em, res: eres, exc: eexc, wdata: ewd, strb: estrb, size: esize, lat: elat};
        vq.push_back(v);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t  o;
        stim_t s;
        exp_t  e;
        rst = 1'b0; exu_valid = 0; exu_data = '0; mem_req_ready = 0;
        mem_rsp_valid = 0; mem_rsp_rdata = '0; mem_rsp_err = 0; wbu_ready = 0;
        repeat (3) @(negedge clk);
        chk("reset lsu_ready", 64'(lsu_ready), 64'd1);
        chk("reset lsu_valid", 64'(lsu_valid), 64'd0);
        chk("reset mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("reset lsu_data", 64'(lsu_data), 64'd0);
        chk("reset lsu_exc", 64'(lsu_exc), 64'd0);
        chk("reset wstrb", 64'(mem_req_wstrb), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        //       ren wen op      addr          wdata         rdata         err rd rs ws  mem res           exc wdata         strb  sz lat
        add_vec(1, 0, 3'd0, 32'h8000_0003, 32'h0,        32'h80FF_FF00, 0, 2, 0, 0,  1, 32'hFFFF_FF80, 0, 32'h0,        4'h0, 0, 5);
        add_vec(1, 0, 3'd5, 32'h8000_0002, 32'h0,        32'hABCD_1234, 0, 0, 0, 0,  1, 32'h0000_ABCD, 0, 32'h0,        4'h0, 1, 3);
        add_vec(1, 0, 3'd1, 32'h8000_0002, 32'h0,        32'hABCD_1234, 0, 0, 0, 1,  1, 32'hFFFF_ABCD, 0, 32'h0,        4'h0, 1, 3);
        add_vec(0, 1, 3'd0, 32'h8000_0001, 32'h0000_005A, 32'h0,        0, 0, 0, 0,  1, 32'h0,         0, 32'h0000_5A00, 4'h2, 0, 3);
        add_vec(0, 1, 3'd2, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0,        0, 1, 0, 0,  1, 32'h0,         0, 32'hDEAD_BEEF, 4'hF, 2, 4);
        add_vec(1, 0, 3'd2, 32'h8000_0002, 32'h0,        32'h0,         0, 0, 0, 0,  0, 32'h0,         1, 32'h0,        4'h0, 0, 1);
        add_vec(0, 1, 3'd1, 32'h8000_0003, 32'h1234,     32'h0,         0, 0, 0, 0,  0, 32'h0,         2, 32'h0,        4'h0, 0, 1);
        add_vec(0, 0, 3'd2, 32'h8000_0005, 32'hFFFF_FFFF, 32'h0,        0, 0, 0, 2,  0, 32'h0,         0, 32'h0,        4'h0, 0, 1);
        add_vec(1, 0, 3'd2, 32'h8000_0004, 32'h0,        32'h1234_5678, 1, 1, 0, 0,  1, 32'h0,         3, 32'h0,        4'h0, 2, 4);
        add_vec(1, 1, 3'd0, 32'h8000_0002, 32'hFFFF_FF77, 32'h0,        0, 0, 0, 0,  1, 32'h0,         0, 32'h0077_0000, 4'h4, 0, 3);
        add_vec(1, 0, 3'd7, 32'h8000_0008, 32'h0,        32'h8765_4321, 0, 0, 0, 0,  1, 32'h8765_4321, 0, 32'h0,        4'h0, 2, 3);
        add_vec(1, 0, 3'd4, 32'h8000_0001, 32'h0,        32'h0000_8000, 0, 0, 0, 0,  1, 32'h0000_0080, 0, 32'h0,        4'h0, 0, 3);
        add_vec(1, 0, 3'd2, 32'h8000_0010, 32'h0,        32'hCAFE_F00D, 0, 1, 4, 3,  1, 32'hCAFE_F00D, 0, 32'h0,        4'h0, 2, 8);
        add_vec(0, 1, 3'd1, 32'h8000_0002, 32'hAAAA_5555, 32'h0,        0, 0, 0, 0,  1, 32'h0,         0, 32'h5555_0000, 4'hC, 1, 3);

        for (int i = 0; i < vq.size(); i++) begin
            run_txn(vq[i].s, o);
            verify($sformatf("vec%0d", i), vq[i].s, vq[i].e, o);
        end

        // Reset while waiting on a response, then a stray response in IDLE.
        exu_valid = 1'b1;
        exu_data  = {32'h8000_0020, 1'b1, 1'b0, 3'd2, 32'h0, 39'h11};
        @(negedge clk);
        exu_valid = 1'b0; exu_data = '0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("wait lsu_ready", 64'(lsu_ready), 64'd0);
        chk("wait mem_req_valid", 64'(mem_req_valid), 64'd0);
        rst = 1'b0;
        #1;
        chk("async reset lsu_ready", 64'(lsu_ready), 64'd1);
        chk("async reset lsu_valid", 64'(lsu_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEAD_0000; mem_rsp_err = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        @(negedge clk);
        chk("stray rsp lsu_valid", 64'(lsu_valid), 64'd0);
        chk("stray rsp lsu_ready", 64'(lsu_ready), 64'd1);
        chk("stray rsp mem_req_valid", 64'(mem_req_valid), 64'd0);
        s = '{ren: 0, wen: 0, op: 3'd0, addr: 32'h0, wdata: 32'h0, rdata: 32'h0, err: 0,
              pass: 39'h55_AA55_AA55, rd: 0, rs: 0, ws: 0, stray: 0};
        run_txn(s, o);
        verify("post_reset_nonmem", s, model(s), o);

        for (int i = 0; i < 200; i++) begin
            s.ren = 1'($urandom_range(0, 1));
            s.wen = 1'($urandom_range(0, 1));
            s.op  = 3'($urandom_range(0, 7));
            s.addr  = 32'h8000_0000 | ($urandom & 32'hFF);
            s.wdata = $urandom;
            s.rdata = $urandom;
            s.err   = ($urandom_range(0, 7) == 0);
            s.pass  = 39'({$urandom, $urandom});
            s.rd = $urandom_range(0, 3);
            s.rs = $urandom_range(0, 2);
            s.ws = $urandom_range(0, 2);
            s.stray = 1'($urandom_range(0, 1));
            run_txn(s, o);
            verify($sformatf("rnd%0d", i), s, model(s), o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mc.md
Name: lsu_mc

Overview:
Multi-cycle load/store unit between EXU and WBU; successor to the fixed-width DPI LSU. Accepts one packed instruction per valid/ready handshake. It issues at most one transaction on a generic variable-latency memory request/response port, aligns and sign/zero-extends load data, generates store byte strobes, and flags misaligned accesses and bus errors. Non-memory instructions pass through with one-cycle latency.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; must be 32 or 64
PASS_W, 39, sideband bits forwarded untouched to WBU
STRB_W, DATA_W/8, derived byte-strobe width; not overridable

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
exu_valid  in  1  EXU request valid
exu_data  in  ADDR_W+2+3+DATA_W+PASS_W  packed {addr, ren, wen, op[2:0], wdata, pass}; MSB first
lsu_ready  out  1  LSU can accept
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  request address, byte address, unaligned low bits kept
mem_req_wen  out  1  1 = write
mem_req_wdata  out  DATA_W  store data, lane-shifted
mem_req_wstrb  out  STRB_W  byte strobes; 0 for reads
mem_req_size  out  2  log2 bytes
mem_rsp_valid  in  1  response valid; always accepted
mem_rsp_rdata  in  DATA_W  full-lane read data
mem_rsp_err  in  1  bus error
lsu_valid  out  1  result valid to WBU
lsu_data  out  DATA_W+PASS_W  {load_result, pass}
lsu_exc  out  2  00 none, 01 misaligned load, 10 misaligned store, 11 bus error
wbu_ready  in  1  WBU accepts

Behaviour:
- op encoding (funct3): 000 B, 001 H, 010 W, 011 D (DATA_W=64 only), 100 BU, 101 HU, 110 WU (64 only). Stores use op[1:0] only. Undefined op -> treat as W.
- States: IDLE, REQ, WAIT, OUT. Reset: state IDLE, all outputs 0 except lsu_ready=1.
- IDLE: lsu_ready=1. On exu_valid:
  - ren=wen=0 -> latch, go OUT (latency 1, load_result=0).
  - Misaligned (addr not multiple of size) -> OUT with lsu_exc=01/10, no memory access.
  - Otherwise -> REQ.
  - ren=wen=1 -> treat as store.
- REQ: mem_req_valid=1 with all fields stable until mem_req_ready. On the handshake cycle go WAIT. A response in the same cycle as the request is not allowed; the memory side guarantees at least 1 cycle.
- WAIT: on mem_rsp_valid capture rdata and err, go OUT. Store responses also wait here; no posted writes.
- OUT: lsu_valid=1 with data and exc held stable until wbu_ready, then go IDLE. lsu_ready=0 in REQ, WAIT and OUT; no overlap in this generation.
- Load extract: byte lane = addr[log2(STRB_W)-1:0]. Shift rdata right by lane*8, then sign-extend (B/H/W) or zero-extend (BU/HU/WU) to DATA_W.
- Store: wdata replicated or shifted into the lane. wstrb = ((1<<size)-1) << lane.
- mem_rsp_err=1 -> lsu_exc=11, load_result=0.
- Asynchronous reset mid-transaction returns to IDLE immediately. Any later response for the abandoned request is ignored while IDLE.
- mem_rsp_valid in IDLE, REQ or OUT is ignored.

Decomposition:
- Package lsu_pkg: state enum lsu_state_t; op localparams; lsu_exc_t codes; function size_of(op).
- One sub-module: lsu_align, combinational. Holds the load extract/extend and the store shift/strobe logic; parameter DATA_W. Instantiated once.

Test Plan:
- LB at 0x8000_0003, mem returns 0x80FF_FF00 after 3 cycles -> lsu_data[load]=0xFFFF_FF80, exc=00, lsu_valid 5 cycles after accept.
- LHU at 0x8000_0002, rdata 0xABCD_1234 -> result 0x0000_ABCD; LH -> 0xFFFF_ABCD.
- SB 0x5A at 0x8000_0001 -> wdata byte1=0x5A, wstrb=0010, wen=1; SW at 0x8000_0000 -> wstrb=1111.
- LW at 0x8000_0002 -> no mem_req_valid, lsu_exc=01 on the next cycle; SH at odd address -> exc=10.
- mem_req_ready held low 4 cycles and wbu_ready low 3 cycles -> request and output fields stable, single transaction, lsu_ready stays 0.
- Reset asserted in WAIT, then a stray mem_rsp_valid -> state IDLE, lsu_valid=0, response ignored; next non-mem op completes in 1 cycle.
